// File: rtl/kdf_msg_streamer.sv
// Purpose: fetches a byte-length message from a word buffer, streams it to kmac as strobed beats, then captures the digest.
// Latency: one buffer read per beat (read, hold, send), so at most one beat every 2 cycles; done_o is high in the FINISH cycle.
// Backpressure: a beat is held (data/strb/last stable) while kdf_ready_i is low; start_i is ignored while busy.
module kdf_msg_streamer #(
  parameter int DataW         = 64,
  parameter int MaxBytes      = 256,
  parameter int DigestW       = 256,
  parameter int TimeoutCycles = 1024
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic [$clog2(MaxBytes+1)-1:0]    len_i,
  output logic                             rd_req_o,
  output logic [$clog2(MaxBytes/8)-1:0]    rd_addr_o,
  input  logic [DataW-1:0]                 rd_data_i,
  output logic                             kdf_valid_o,
  output logic [DataW-1:0]                 kdf_data_o,
  output logic [DataW/8-1:0]               kdf_strb_o,
  output logic                             kdf_last_o,
  input  logic                             kdf_ready_i,
  input  logic                             kdf_done_i,
  input  logic [DigestW-1:0]               kdf_digest0_i,
  input  logic [DigestW-1:0]               kdf_digest1_i,
  input  logic                             kdf_error_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [1:0]                       err_code_o,
  output logic [DigestW-1:0]               digest_o
);

  localparam int StrbW = DataW / 8;
  localparam int LenW  = $clog2(MaxBytes + 1);
  localparam int AddrW = $clog2(MaxBytes / 8);
  localparam int OffW  = $clog2(StrbW);
  localparam int CntW  = $clog2(TimeoutCycles);

  localparam logic [1:0] ErrNone    = 2'd0;
  localparam logic [1:0] ErrBadLen  = 2'd1;
  localparam logic [1:0] ErrKmac    = 2'd2;
  localparam logic [1:0] ErrTimeout = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_SEND,
    S_WAIT_DONE,
    S_FINISH
  } state_e;

  state_e               state_q, state_d;
  logic [AddrW-1:0]     addr_q, addr_d;
  logic [AddrW-1:0]     last_idx_q, last_idx_d;
  logic [OffW-1:0]      tail_q, tail_d;
  logic [DataW-1:0]     beat_q, beat_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 done_q, done_d;
  logic [1:0]           err_q, err_d;
  logic [DigestW-1:0]   digest_q, digest_d;

  logic                 len_ok;
  logic                 last_beat;
  logic [LenW:0]        beats_w;
  logic [LenW:0]        last_idx_w;
  logic [StrbW-1:0]     tail_mask;
  logic                 in_send;

  localparam logic [StrbW-1:0] StrbOne = {{(StrbW-1){1'b0}}, 1'b1};

  // Beat bookkeeping: length check, beat count, last-beat detect and the partial strobe.
  always_comb begin
    len_ok     = (len_i != '0) && (len_i <= LenW'(MaxBytes));
    beats_w    = ({1'b0, len_i} + (LenW+1)'(StrbW - 1)) >> OffW;
    last_idx_w = beats_w - (LenW+1)'(1);
    last_beat  = (addr_q == last_idx_q);
    tail_mask  = (tail_q == '0) ? '1 : ((StrbOne << tail_q) - StrbOne);
    in_send    = (state_q == S_SEND);
  end

  // Next-state logic and the combinational read request.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    last_idx_d = last_idx_q;
    tail_d     = tail_q;
    beat_d     = beat_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    err_d      = err_q;
    digest_d   = digest_q;
    rd_req_o   = 1'b0;
    rd_addr_o  = '0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_ok) begin
            last_idx_d = last_idx_w[AddrW-1:0];
            tail_d     = len_i[OffW-1:0];
            addr_d     = '0;
            err_d      = ErrNone;
            rd_req_o   = 1'b1;
            rd_addr_o  = '0;
            state_d    = S_FETCH;
          end else begin
            // Rejected request: report and stay idle; digest untouched.
            done_d = 1'b1;
            err_d  = ErrBadLen;
          end
        end
      end

      S_FETCH: begin
        if (kdf_error_i) begin
          err_d   = ErrKmac;
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          beat_d  = rd_data_i;
          state_d = S_SEND;
        end
      end

      S_SEND: begin
        if (kdf_error_i) begin
          err_d   = ErrKmac;
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else if (kdf_ready_i) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = S_WAIT_DONE;
          end else begin
            addr_d    = addr_q + AddrW'(1);
            rd_req_o  = 1'b1;
            rd_addr_o = addr_q + AddrW'(1);
            state_d   = S_FETCH;
          end
        end
      end

      S_WAIT_DONE: begin
        cnt_d = cnt_q + CntW'(1);
        if (kdf_error_i) begin
          err_d   = ErrKmac;
          done_d  = 1'b1;
          state_d = S_FINISH;
        end else if (kdf_done_i) begin
          digest_d = kdf_digest0_i ^ kdf_digest1_i;
          err_d    = ErrNone;
          done_d   = 1'b1;
          state_d  = S_FINISH;
        end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
          err_d   = ErrTimeout;
          done_d  = 1'b1;
          state_d = S_FINISH;
        end
      end

      S_FINISH: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears everything at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      last_idx_q <= '0;
      tail_q     <= '0;
      beat_q     <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      err_q      <= ErrNone;
      digest_q   <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      last_idx_q <= last_idx_d;
      tail_q     <= tail_d;
      beat_q     <= beat_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      digest_q   <= digest_d;
    end
  end

  // Beat outputs are qualified by SEND so idle strobe/last read as zero.
  always_comb begin
    kdf_valid_o = in_send;
    kdf_data_o  = beat_q;
    kdf_strb_o  = in_send ? (last_beat ? tail_mask : '1) : '0;
    kdf_last_o  = in_send && last_beat;
    busy_o      = (state_q != S_IDLE);
    done_o      = done_q;
    err_code_o  = err_q;
    digest_o    = digest_q;
  end

endmodule

// File: doc/kdf_msg_streamer.md
Name: kdf_msg_streamer

Overview:
- Upstream feeder for the kmac keymgr KDF data port.
- Fetches a byte-length message from a synchronous word buffer and streams it as 64-bit beats (valid/data/strb/last) into kmac.
- Waits for kmac done, then captures the unmasked digest and reports status to the key-derivation controller.
- Sits between keymgr's message buffer and kmac; used by the kmac fuzzing bench as a stimulus front-end.

Parameters:
DataW, 64, beat width in bits; strobe width is DataW/8
MaxBytes, 256, largest accepted message length in bytes
DigestW, 256, captured digest width per share
TimeoutCycles, 1024, maximum cycles allowed in WAIT_DONE

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
start_i  in  1  one-cycle request to send a message
len_i  in  $clog2(MaxBytes+1)  message length in bytes, sampled at start
rd_req_o  out  1  buffer read strobe
rd_addr_o  out  $clog2(MaxBytes/8)  buffer word address
rd_data_i  in  DataW  buffer data, valid exactly 1 cycle after rd_req_o
kdf_valid_o  out  1  beat valid to kmac
kdf_data_o  out  DataW  beat data
kdf_strb_o  out  DataW/8  byte strobe
kdf_last_o  out  1  final beat marker
kdf_ready_i  in  1  kmac accepts beat
kdf_done_i  in  1  kmac digest ready
kdf_digest0_i  in  DigestW  digest share 0
kdf_digest1_i  in  DigestW  digest share 1
kdf_error_i  in  1  kmac error
busy_o  out  1  transaction in progress
done_o  out  1  one-cycle completion pulse
err_code_o  out  2  0 none, 1 bad length, 2 kmac error, 3 timeout
digest_o  out  DigestW  share0 XOR share1, captured at done

Behaviour:
- Clock is clk_i. Reset is rst_i, asynchronous and active-high.
- Reset values: all outputs 0; FSM in IDLE; address, beat and timeout counters 0.
- FSM states: IDLE, FETCH, SEND, WAIT_DONE, FINISH.
- IDLE, start_i with len_i==0 or len_i>MaxBytes: no buffer read and no kdf traffic; next cycle done_o=1, err_code_o=1; remain IDLE.
- IDLE, start_i with valid length:
  - Latch len_i and set beats = ceil(len/8).
  - Assert rd_req_o with rd_addr_o=0 in the same cycle; go to FETCH; busy_o=1.
- FETCH (one cycle): register rd_data_i into the beat holding register; go to SEND.
- SEND:
  - kdf_valid_o=1 with registered data. Data, strb and last stay stable until kdf_ready_i.
  - kdf_strb_o is all-ones except on the last beat, where it is (1<<(len%8))-1, or all-ones if len%8==0.
  - kdf_last_o=1 only on beat beats-1.
  - On handshake with last: go to WAIT_DONE and clear the timeout counter.
  - On handshake otherwise: increment the address, assert rd_req_o the same cycle, go to FETCH.
  - Peak throughput is one beat per 2 cycles.
- WAIT_DONE: the counter increments each cycle. Priority order:
  1. kdf_error_i: err_code=2.
  2. kdf_done_i: capture digest_o = digest0 ^ digest1, err_code=0.
  3. Counter reaching TimeoutCycles-1: err_code=3.
  - Any of these goes to FINISH.
- FINISH (one cycle): done_o=1, busy_o=0 from the next cycle; return to IDLE.
- digest_o and err_code_o hold their values until the next accepted start.
- On a bad-length start, digest_o is unchanged.
- start_i while busy_o=1 is ignored; there is no queueing.
- kdf_error_i seen in SEND or FETCH aborts the transaction:
  - Drop kdf_valid_o next cycle, err_code=2, go to FINISH.
- kdf_done_i outside WAIT_DONE is ignored.
- Reset asserted mid-transaction clears everything immediately. kdf_valid_o falls asynchronously, with no trailing beat.
- rd_req_o is asserted only in IDLE→FETCH and SEND→FETCH transitions. Addresses never exceed beats-1.

Test Plan:
- len=16, ready tied high, buffer words A,B, done after 5 cycles with share0=X, share1=Y -> exactly 2 beats; strb FF/FF; last on beat 2; done_o pulse; digest_o=X^Y; err_code_o=0.
- len=13 -> 2 beats; second strb=0x1F; last=1 on beat 2 only.
- len=0, then len=MaxBytes+1 -> no rd_req_o and no kdf_valid_o; done_o pulse with err_code_o=1 each time; digest_o unchanged.
- len=24 with kdf_ready_i low for 7 cycles on beat 2 -> data, strb and last held stable throughout; exactly 3 handshakes; address sequence 0,1,2.
- Done never asserted -> done_o exactly TimeoutCycles+1 cycles after the last handshake, err_code_o=3.
- kdf_error_i pulse during WAIT_DONE -> err_code_o=2.
- rst_i mid-SEND -> kdf_valid_o=0 immediately; a new start afterwards completes normally.
- start_i pulsed while busy -> ignored, only one transaction's worth of beats.
